// File: rtl/ex_src_stage.sv
// ID/EX pipeline register with the EX-stage operand select and MEM/WB forwarding network.
// Optional macro EX_SRC_FWD_EN enables forwarding; without it the operands come straight from rd1/rd2.
module ex_src_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_rd1,
  input  logic [WIDTH-1:0] id_rd2,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_alu_ctrl,
  input  logic             id_alusrc_a,
  input  logic             id_alusrc_b,
  input  logic             id_reg_write,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [WIDTH-1:0] mem_alu_res,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_result,
  output logic             ex_valid,
  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic [2:0]       control,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [WIDTH-1:0] ex_pc,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write
);

  localparam int unsigned RegW  = 5;
  localparam int unsigned CtrlW = 3;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [RegW-1:0]  rs1;
    logic [RegW-1:0]  rs2;
    logic [RegW-1:0]  rd;
    logic [CtrlW-1:0] alu_ctrl;
    logic             alusrc_a;
    logic             alusrc_b;
    logic             reg_write;
  } idex_t;

  idex_t            r_idex;
  idex_t            w_load;
  logic [WIDTH-1:0] w_fa;
  logic [WIDTH-1:0] w_fb;

  assign w_load = '{
    valid:     id_valid,
    pc:        id_pc,
    rd1:       id_rd1,
    rd2:       id_rd2,
    imm:       id_imm,
    rs1:       id_rs1,
    rs2:       id_rs2,
    rd:        id_rd,
    alu_ctrl:  id_alu_ctrl,
    alusrc_a:  id_alusrc_a,
    alusrc_b:  id_alusrc_b,
    reg_write: id_reg_write
  };

  // Pipeline register: reset and flush both insert an all-zero bubble; stall holds.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_idex <= '0;
    end else if (!stall) begin
      r_idex <= w_load;
    end
  end

`ifdef EX_SRC_FWD_EN
  // MEM is the younger producer, so it is checked before WB; x0 never forwards.
  always_comb begin
    w_fa = r_idex.rd1;
    if (mem_reg_write && (mem_rd != RegW'(0)) && (mem_rd == r_idex.rs1)) begin
      w_fa = mem_alu_res;
    end else if (wb_reg_write && (wb_rd != RegW'(0)) && (wb_rd == r_idex.rs1)) begin
      w_fa = wb_result;
    end
  end

  always_comb begin
    w_fb = r_idex.rd2;
    if (mem_reg_write && (mem_rd != RegW'(0)) && (mem_rd == r_idex.rs2)) begin
      w_fb = mem_alu_res;
    end else if (wb_reg_write && (wb_rd != RegW'(0)) && (wb_rd == r_idex.rs2)) begin
      w_fb = wb_result;
    end
  end
`else
  logic w_unused_fwd;

  assign w_fa = r_idex.rd1;
  assign w_fb = r_idex.rd2;
  // Forward-source ports stay on the interface but are not consumed in this build.
  assign w_unused_fwd = ^{mem_reg_write, mem_rd, mem_alu_res, wb_reg_write, wb_rd, wb_result};
`endif

  assign SrcA          = r_idex.alusrc_a ? r_idex.pc  : w_fa;
  assign SrcB          = r_idex.alusrc_b ? r_idex.imm : w_fb;
  assign ex_store_data = w_fb;
  assign ex_valid      = r_idex.valid;
  assign control       = r_idex.alu_ctrl;
  assign ex_pc         = r_idex.pc;
  assign ex_rd         = r_idex.rd;
  assign ex_reg_write  = r_idex.reg_write & r_idex.valid;

endmodule
